instr_fetch_aligner: RTL
========================

INSTR_FETCH_ALIGNER -- requirements
Module: instr_fetch_aligner

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): FETCH_W, 32, fetch word width in bits (32 or 64); QDEPTH, 8, halfword queue depth (power of 2, >= 2*FETCH_W/16); RESET_PC, 32'h0000_0000, PC after reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning): aclk, in, 1, clock; aresetn, in, 1, reset, synchronous, active-low.
REQ-003 flush, in, 1, redirect request; flush_pc, in, 32, redirect target (bit 0 ignored, treated as 0).
REQ-004 fetch_addr, out, 32, FETCH_W/8-aligned byte address of the next word expected from upstream.
REQ-005 fetch_valid, in, 1; fetch_ready, out, 1; fetch_data, in, FETCH_W, word at fetch_addr, little-endian halfwords.
REQ-006 instr_valid, out, 1; instr_ready, in, 1; instr_data, out, 32, raw instruction, upper 16 bits zero when compressed.
REQ-007 instr_pc, out, 32, byte address of instr_data; instr_is_comp, out, 1, high when instr_data[1:0] != 2'b11.

Function
REQ-008 A fetch handshake (fetch_valid & fetch_ready) SHALL push the FETCH_W/16 halfwords of fetch_data into the queue, lowest address first, and advance fetch_addr by FETCH_W/8.
REQ-009 For the first word after reset or flush, halfwords below the start offset (pc[log2(FETCH_W/8)-1:1]) SHALL be discarded, not pushed.
REQ-010 fetch_ready SHALL be high iff queue free slots >= FETCH_W/16, computed from registered state only; no combinational path from instr_ready to fetch_ready.
REQ-011 instr_valid SHALL be high iff count >= 1 and head[1:0] != 2'b11, or count >= 2; computed from registered state only.
REQ-012 Compressed head: instr_data = {16'h0, head}, instr_is_comp = 1; otherwise instr_data = {head+1, head}, instr_is_comp = 0.
REQ-013 An instr handshake SHALL pop 1 halfword (compressed) or 2 (uncompressed) and advance instr_pc by 2 or 4 respectively, wrapping mod 2^32.
REQ-014 Push and pop in the same cycle SHALL both take effect; count' = count + pushed - popped.
REQ-015 Latency: a word accepted in cycle N SHALL make a dependent instruction visible on instr_valid no earlier and no later than cycle N+1.
REQ-016 A 32-bit instruction whose halves straddle two fetch words SHALL be held (instr_valid low) until its upper halfword is pushed.
REQ-017 While instr_valid & ~instr_ready, instr_data, instr_pc, instr_is_comp SHALL remain stable.
REQ-018 Flush SHALL take priority: in the flush cycle, same-cycle fetch and instr handshakes are ignored; next cycle queue empty, instr_valid = 0, instr_pc = flush_pc & ~1, fetch_addr = flush_pc aligned down to FETCH_W/8, start offset from flush_pc.
REQ-019 Partially received 32-bit instructions SHALL be discarded by flush.
REQ-020 Queue pointers SHALL wrap modulo QDEPTH; overflow and underflow SHALL be impossible by construction of REQ-010/REQ-011.

Reset
REQ-021 While aresetn = 0 at a rising aclk edge: queue empty (count 0), instr_valid = 0, instr_data = 0, instr_is_comp = 0, instr_pc = RESET_PC, fetch_addr = RESET_PC aligned down, start offset from RESET_PC.
REQ-022 Reset asserted mid-operation SHALL discard all queued halfwords and any partial instruction identically to REQ-021.
REQ-023 fetch_ready SHALL be 1 in the first cycle after reset release.

Verification (FETCH_W = 32, RESET_PC = 0)
REQ-024 Word 0x00000013 at fetch_addr 0x0 -> one instr: data 0x00000013, pc 0x0, is_comp 0, one cycle after accept; fetch_addr becomes 0x4.
REQ-025 Word 0x45014501 -> two instrs 0x00004501 at pc 0x0 and 0x2, is_comp 1; with instr_ready held 1, on consecutive cycles.
REQ-026 Straddle: words 0x00134501 then 0x45010000 -> 0x00004501 @0x0, 0x00000013 @0x2 (valid only after second word accepted), 0x00004501 @0x6.
REQ-027 Flush with flush_pc = 0x102, then word 0x00134501 at 0x100 and word 0x00000000 at 0x104 -> fetch_addr 0x100 after flush; low half dropped; first instr 0x00000013 @0x102.
REQ-028 instr_ready = 0 for 10 cycles with fetch_valid = 1 continuously -> fetch_ready falls when free < 2; outputs stable; after release, every halfword is emitted in order, none lost or duplicated.
REQ-029 aresetn = 0 for one cycle while the queue holds 6 halfwords -> next cycle instr_valid = 0, instr_pc = 0x0, fetch_addr = 0x0, fetch_ready = 1.

Source files
------------

// File: rtl/instr_fetch_aligner.sv
// Instruction fetch aligner: splits fetch words into a halfword queue and
// presents whole RV compressed (16-bit) or standard (32-bit) instructions.
module instr_fetch_aligner #(
  parameter int          FETCH_W  = 32,
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic [31:0]        fetch_addr,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr_data,
  output logic [31:0]        instr_pc,
  output logic               instr_is_comp
);

  localparam int          HW         = FETCH_W / 16;
  localparam int          OFFW       = $clog2(FETCH_W / 8);
  localparam int          SW         = OFFW - 1;
  localparam int          AW         = $clog2(QDEPTH);
  localparam int          CW         = AW + 1;
  localparam logic [31:0] ALIGN_MASK = ~32'(FETCH_W / 8 - 1);

  logic [15:0]   q_mem [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_q, faddr_q;
  logic [SW-1:0] start_off;
  logic          first_word;

  logic [15:0]   head_lo, head_hi;
  logic          head_comp;
  logic [SW-1:0] skip;
  logic [CW-1:0] push_n, pop_n;
  logic          fetch_fire, instr_fire;

  assign fetch_addr = faddr_q;
  assign instr_pc   = pc_q;

  // Handshake decode: everything below depends on registered state only,
  // except the fire terms which merely qualify the updates.
  always_comb begin
    head_lo       = q_mem[rd_ptr];
    head_hi       = q_mem[rd_ptr + AW'(1)];
    head_comp     = head_lo[1:0] != 2'b11;
    fetch_ready   = (CW'(QDEPTH) - count) >= CW'(HW);
    instr_valid   = (count >= CW'(2)) || ((count != '0) && head_comp);
    instr_is_comp = (count != '0) && head_comp;
    instr_data    = 32'h0;
    if (count != '0) begin
      if (head_comp || (count < CW'(2)))
        instr_data = {16'h0, head_lo};
      else
        instr_data = {head_hi, head_lo};
    end
    fetch_fire = fetch_valid & fetch_ready;
    instr_fire = instr_valid & instr_ready;
    skip       = first_word ? start_off : '0;
    push_n     = fetch_fire ? (CW'(HW) - CW'(skip)) : '0;
    pop_n      = instr_fire ? (instr_is_comp ? CW'(1) : CW'(2)) : '0;
  end

  // Queue storage: halfwords below the start offset of the first word are dropped.
  always_ff @(posedge aclk) begin
    if (aresetn && !flush && fetch_fire) begin
      for (int i = 0; i < HW; i++) begin
        if (i >= int'(skip))
          q_mem[wr_ptr + AW'(i - int'(skip))] <= fetch_data[16*i +: 16];
      end
    end
  end

  // Control state: pointers, occupancy, PCs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pc_q       <= RESET_PC;
      faddr_q    <= RESET_PC & ALIGN_MASK;
      start_off  <= RESET_PC[OFFW-1:1];
      first_word <= 1'b1;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pc_q       <= flush_pc & 32'hFFFF_FFFE;
      faddr_q    <= flush_pc & ALIGN_MASK;
      start_off  <= flush_pc[OFFW-1:1];
      first_word <= 1'b1;
    end else begin
      if (fetch_fire) begin
        wr_ptr     <= wr_ptr + AW'(push_n);
        faddr_q    <= faddr_q + 32'(FETCH_W / 8);
        first_word <= 1'b0;
      end
      if (instr_fire) begin
        rd_ptr <= rd_ptr + AW'(pop_n);
        pc_q   <= pc_q + (32'(pop_n) << 1);
      end
      count <= count + push_n - pop_n;
    end
  end

endmodule
